duty_ramp: RTL and testbench

DUTY_RAMP -- requirements
Module: duty_ramp

---
 rtl/duty_ramp.sv | 188 ++++++++++++++++++
 tb/tb_duty_ramp.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/duty_ramp.sv
// duty_ramp: triangular duty-cycle sequencer for a downstream PWM stage.
// Walks duty from min_duty up to max_duty, dwells, walks back down, dwells,
// and repeats. All progress is gated by period_end so the duty value only
// moves at PWM period boundaries.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   enable        1 = run the ramp, 0 = park at zero (applied on period_end)
//   period_end    single-cycle strobe from the PWM counter wrap
//   min_duty      lower ramp bound
//   max_duty      upper ramp bound
//   step_div      one ramp step every step_div+1 period_end strobes
//   hold_periods  dwell at each bound for hold_periods+1 periods
//   duty          registered compare value
//   duty_update   one-cycle pulse when duty has just taken a new value
//   cycle_done    one-cycle pulse after HOLD_LO hands over to RISE
//   state         encoded FSM state (IDLE=0 RISE=1 HOLD_HI=2 FALL=3 HOLD_LO=4)
module duty_ramp #(
  parameter int unsigned DUTY_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              period_end,
  input  logic [DUTY_W-1:0] min_duty,
  input  logic [DUTY_W-1:0] max_duty,
  input  logic [CNT_W-1:0]  step_div,
  input  logic [CNT_W-1:0]  hold_periods,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_update,
  output logic              cycle_done,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RISE    = 3'd1,
    S_HOLD_HI = 3'd2,
    S_FALL    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               duty_update_q, duty_update_d;
  logic               cycle_done_q, cycle_done_d;

  logic [DUTY_W-1:0]  duty_inc;
  logic [DUTY_W-1:0]  duty_dec;
  logic               state_legal;
  logic               div_hit;
  logic               hold_hit;

  // Only consumed when duty is strictly inside the bounds, so these never wrap.
  assign duty_inc    = duty_q + DUTY_W'(1);
  assign duty_dec    = duty_q - DUTY_W'(1);
  assign state_legal = (state_q <= S_HOLD_LO);
  assign div_hit     = (div_cnt_q == step_div);
  assign hold_hit    = (hold_cnt_q == hold_periods);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    div_cnt_d    = div_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    cycle_done_d = 1'b0;

    if (!state_legal) begin
      // Corrupted encoding: recover without waiting for a strobe.
      state_d    = S_IDLE;
      duty_d     = '0;
      div_cnt_d  = '0;
      hold_cnt_d = '0;
    end else if (period_end) begin
      if (!enable) begin
        state_d    = S_IDLE;
        duty_d     = '0;
        div_cnt_d  = '0;
        hold_cnt_d = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            duty_d    = min_duty;
            div_cnt_d = '0;
            state_d   = S_RISE;
          end

          S_RISE: begin
            if (!div_hit) begin
              div_cnt_d = div_cnt_q + CNT_W'(1);
            end else begin
              div_cnt_d = '0;
              if (duty_q >= max_duty) begin
                // Also covers min_duty >= max_duty: clamp straight to the top.
                duty_d     = max_duty;
                state_d    = S_HOLD_HI;
                hold_cnt_d = '0;
              end else begin
                duty_d = duty_inc;
                if (duty_inc == max_duty) begin
                  state_d    = S_HOLD_HI;
                  hold_cnt_d = '0;
                end
              end
            end
          end

          S_FALL: begin
            if (!div_hit) begin
              div_cnt_d = div_cnt_q + CNT_W'(1);
            end else begin
              div_cnt_d = '0;
              if (duty_q <= min_duty) begin
                duty_d     = min_duty;
                state_d    = S_HOLD_LO;
                hold_cnt_d = '0;
              end else begin
                duty_d = duty_dec;
                if (duty_dec == min_duty) begin
                  state_d    = S_HOLD_LO;
                  hold_cnt_d = '0;
                end
              end
            end
          end

          S_HOLD_HI: begin
            if (hold_hit) begin
              state_d    = S_FALL;
              hold_cnt_d = '0;
              div_cnt_d  = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
          end

          S_HOLD_LO: begin
            if (hold_hit) begin
              state_d      = S_RISE;
              hold_cnt_d   = '0;
              div_cnt_d    = '0;
              cycle_done_d = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
          end

          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end

    // Pulse only when the stored value actually changes.
    duty_update_d = (duty_d != duty_q);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      duty_q        <= '0;
      div_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      duty_update_q <= 1'b0;
      cycle_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      duty_q        <= duty_d;
      div_cnt_q     <= div_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      duty_update_q <= duty_update_d;
      cycle_done_q  <= cycle_done_d;
    end
  end

  assign duty        = duty_q;
  assign duty_update = duty_update_q;
  assign cycle_done  = cycle_done_q;
  assign state       = 3'(state_q);

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp: a table of per-period vectors plus hand
// sequences for the full-range ramp, disable while frozen, and async reset.
module tb_duty_ramp;

  localparam int ST_IDLE = 0;
  localparam int ST_RISE = 1;
  localparam int ST_HHI  = 2;
  localparam int ST_FALL = 3;
  localparam int ST_HLO  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       period_end;
  logic [7:0] min_duty;
  logic [7:0] max_duty;
  logic [7:0] step_div;
  logic [7:0] hold_periods;
  logic [7:0] duty;
  logic       duty_update;
  logic       cycle_done;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       en;
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] sd;
    logic [7:0] hp;
    int         e_duty;
    int         e_state;
    int         e_cd;
  } vec_t;

  vec_t vecs[$];

  duty_ramp #(.DUTY_W(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .period_end   (period_end),
    .min_duty     (min_duty),
    .max_duty     (max_duty),
    .step_div     (step_div),
    .hold_periods (hold_periods),
    .duty         (duty),
    .duty_update  (duty_update),
    .cycle_done   (cycle_done),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic en, input int mn, input int mx, input int sd,
                     input int hp, input int d, input int s, input int cd);
    vec_t v;
    v.en = en; v.mn = 8'(mn); v.mx = 8'(mx); v.sd = 8'(sd); v.hp = 8'(hp);
    v.e_duty = d; v.e_state = s; v.e_cd = cd;
    vecs.push_back(v);
  endtask

  task automatic set_cfg(input logic en, input int mn, input int mx, input int sd, input int hp);
    enable = en; min_duty = 8'(mn); max_duty = 8'(mx);
    step_div = 8'(sd); hold_periods = 8'(hp);
  endtask

  // One period_end strobe; returns at the falling edge right after it took effect.
  task automatic pulse();
    @(negedge clk) period_end = 1'b1;
    @(negedge clk) period_end = 1'b0;
  endtask

  initial begin
    int prev;
    int last_seen;
    int wrap_seen;
    int exp_d;
    int exp_s;

    rst = 1'b1;
    set_cfg(1'b0, 0, 0, 0, 0);
    period_end = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_duty", duty, 0);
    check("reset_state", state, ST_IDLE);
    check("reset_upd", duty_update, 0);
    check("reset_cd", cycle_done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_upd", duty_update, 0);

    // Basic ramp min=2 max=5 step_div=0 hold=1
    add(1, 2, 5, 0, 1, 2, ST_RISE, 0);
    add(1, 2, 5, 0, 1, 3, ST_RISE, 0);
    add(1, 2, 5, 0, 1, 4, ST_RISE, 0);
    add(1, 2, 5, 0, 1, 5, ST_HHI, 0);
    add(1, 2, 5, 0, 1, 5, ST_HHI, 0);
    add(1, 2, 5, 0, 1, 5, ST_FALL, 0);
    add(1, 2, 5, 0, 1, 4, ST_FALL, 0);
    add(1, 2, 5, 0, 1, 3, ST_FALL, 0);
    add(1, 2, 5, 0, 1, 2, ST_HLO, 0);
    add(1, 2, 5, 0, 1, 2, ST_HLO, 0);
    add(1, 2, 5, 0, 1, 2, ST_RISE, 1);
    add(1, 2, 5, 0, 1, 3, ST_RISE, 0);
    add(0, 2, 5, 0, 1, 0, ST_IDLE, 0);
    // Degenerate bounds min=200 max=100
    add(1, 200, 100, 0, 0, 200, ST_RISE, 0);
    add(1, 200, 100, 0, 0, 100, ST_HHI, 0);
    add(1, 200, 100, 0, 0, 100, ST_FALL, 0);
    add(1, 200, 100, 0, 0, 200, ST_HLO, 0);
    add(1, 200, 100, 0, 0, 200, ST_RISE, 1);
    add(1, 200, 100, 0, 0, 100, ST_HHI, 0);
    add(0, 200, 100, 0, 0, 0, ST_IDLE, 0);
    // Divider step_div=3 min=0 max=2: each value held for 4 strobes
    for (int k = 0; k < 4; k++) add(1, 0, 2, 3, 0, 0, ST_RISE, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 2, 3, 0, 1, ST_RISE, 0);
    add(1, 0, 2, 3, 0, 2, ST_HHI, 0);
    add(1, 0, 2, 3, 0, 2, ST_FALL, 0);
    add(0, 0, 2, 3, 0, 0, ST_IDLE, 0);

    prev = 0;
    foreach (vecs[i]) begin
      set_cfg(vecs[i].en, int'(vecs[i].mn), int'(vecs[i].mx), int'(vecs[i].sd), int'(vecs[i].hp));
      pulse();
      check($sformatf("vec%0d_duty", i), duty, vecs[i].e_duty);
      check($sformatf("vec%0d_state", i), state, vecs[i].e_state);
      check($sformatf("vec%0d_upd", i), duty_update, (vecs[i].e_duty != prev) ? 1 : 0);
      check($sformatf("vec%0d_cd", i), cycle_done, vecs[i].e_cd);
      @(negedge clk);
      check($sformatf("vec%0d_pulse_clear", i), {30'd0, duty_update, cycle_done}, 0);
      @(negedge clk);
      prev = vecs[i].e_duty;
    end

    // Full range 0..255: reaches both ends and never wraps
    set_cfg(1'b1, 0, 255, 0, 0);
    last_seen = 0;
    wrap_seen = 0;
    for (int k = 1; k <= 513; k++) begin
      pulse();
      if (k <= 256)      begin exp_d = k - 1;         exp_s = (k == 256) ? ST_HHI : ST_RISE; end
      else if (k == 257) begin exp_d = 255;           exp_s = ST_FALL; end
      else if (k <= 512) begin exp_d = 255 - (k - 257); exp_s = (k == 512) ? ST_HLO : ST_FALL; end
      else               begin exp_d = 0;             exp_s = ST_RISE; end
      if ((last_seen == 255 && duty == 0) || (last_seen == 0 && duty == 255)) wrap_seen = 1;
      last_seen = int'(duty);
      check($sformatf("full_k%0d_duty", k), duty, exp_d);
      if (k == 256 || k == 257 || k == 512 || k == 513)
        check($sformatf("full_k%0d_state", k), state, exp_s);
    end
    check("full_cd", cycle_done, 1);
    check("full_no_wrap", wrap_seen, 0);
    set_cfg(1'b0, 0, 255, 0, 0);
    pulse();
    check("full_park", state, ST_IDLE);

    // Disable mid-FALL at duty 7, frozen until the next strobe
    set_cfg(1'b1, 0, 10, 0, 0);
    for (int k = 1; k <= 15; k++) pulse();
    check("dis_pre_duty", duty, 7);
    check("dis_pre_state", state, ST_FALL);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check("dis_frozen_duty", duty, 7);
    check("dis_frozen_state", state, ST_FALL);
    pulse();
    check("dis_duty", duty, 0);
    check("dis_state", state, ST_IDLE);
    check("dis_upd", duty_update, 1);

    // Async reset between edges mid-RISE
    set_cfg(1'b1, 3, 9, 0, 0);
    repeat (3) pulse();
    check("ar_pre_duty", duty, 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_duty", duty, 0);
    check("ar_state", state, ST_IDLE);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("ar_no_upd%0d", k), duty_update, 0);
    end
    pulse();
    check("ar_restart_duty", duty, 3);
    check("ar_restart_state", state, ST_RISE);
    check("ar_restart_upd", duty_update, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
